// File: rtl/alarmas_pkg.sv
// Shared levels, one-hot encodings and the raw classifier
// for the hysteresis alarm block.
package alarmas_pkg;

  localparam logic [1:0] LVL_IDLE = 2'd0;
  localparam logic [1:0] LVL_CRIT = 2'd1;
  localparam logic [1:0] LVL_REG  = 2'd2;
  localparam logic [1:0] LVL_ACEP = 2'd3;

  localparam logic [2:0] OUT_IDLE = 3'b000;
  localparam logic [2:0] OUT_CRIT = 3'b001;
  localparam logic [2:0] OUT_REG  = 3'b010;
  localparam logic [2:0] OUT_ACEP = 3'b100;

  // 32-bit operands so threshold plus margin never wraps.
  // Upward moves need the +hy margin, downward use bare thresholds.
  function automatic logic [1:0] classify(
    input logic [31:0] s,
    input logic [1:0]  st,
    input logic [31:0] lo,
    input logic [31:0] hi,
    input logic [31:0] hy
  );
    logic [31:0] lo_up;
    logic [31:0] hi_up;
    logic [1:0]  c;
    lo_up = lo + hy;
    hi_up = hi + hy;
    c     = LVL_CRIT;
    case (st)
      LVL_CRIT: begin
        if (s >= hi_up)      c = LVL_ACEP;
        else if (s >= lo_up) c = LVL_REG;
        else                 c = LVL_CRIT;
      end
      LVL_REG: begin
        if (s < lo)          c = LVL_CRIT;
        else if (s >= hi_up) c = LVL_ACEP;
        else                 c = LVL_REG;
      end
      LVL_ACEP: begin
        if (s < lo)          c = LVL_CRIT;
        else if (s < hi)     c = LVL_REG;
        else                 c = LVL_ACEP;
      end
      default: begin
        if (s < lo)          c = LVL_CRIT;
        else if (s < hi)     c = LVL_REG;
        else                 c = LVL_ACEP;
      end
    endcase
    return c;
  endfunction

  function automatic logic [2:0] lvl2out(input logic [1:0] l);
    logic [2:0] o;
    case (l)
      LVL_CRIT: o = OUT_CRIT;
      LVL_REG:  o = OUT_REG;
      LVL_ACEP: o = OUT_ACEP;
      default:  o = OUT_IDLE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/alarmas_persist.sv
// Persistence filter: a level change is accepted only after
// PERSIST consecutive agreeing valid samples.
module alarmas_persist
  import alarmas_pkg::*;
#(
  parameter int PERSIST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] state,
  input  logic [1:0] raw,
  output logic       take,
  output logic [1:0] new_lvl
);

  localparam int RW = $clog2(PERSIST + 1);
  localparam logic [RW:0] PMAX = (RW + 1)'(PERSIST);

  logic [1:0]    cand_q, cand_d;
  logic [RW-1:0] run_q, run_d;
  logic [RW:0]   run_inc;

  // Track candidate and run length; fire take on the PERSIST-th hit.
  always_comb begin
    cand_d  = cand_q;
    run_d   = run_q;
    run_inc = '0;
    take    = 1'b0;
    new_lvl = state;
    if (clr) begin
      cand_d = state;
      run_d  = '0;
    end else if (en) begin
      if (raw == state) begin
        cand_d = state;
        run_d  = '0;
      end else begin
        if (raw == cand_q) begin
          run_inc = {1'b0, run_q} + 1'b1;
        end else begin
          cand_d  = raw;
          run_inc = (RW + 1)'(1);
        end
        if (run_inc >= PMAX) begin
          take    = 1'b1;
          new_lvl = cand_d;
          run_d   = '0;
        end else begin
          run_d = run_inc[RW-1:0];
        end
      end
    end
  end

  // Candidate / run registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= LVL_IDLE;
      run_q  <= '0;
    end else begin
      cand_q <= cand_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/alarmas_histeresis.sv
// Three-level alarm classifier with hysteresis, persistence,
// sticky critical latch and saturating critical-entry counter.
module alarmas_histeresis
  import alarmas_pkg::*;
#(
  parameter int WIDTH   = 9,
  parameter int TH_LOW  = 103,
  parameter int TH_HIGH = 256,
  parameter int HYST    = 8,
  parameter int PERSIST = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             sum_valid,
  input  logic [WIDTH-1:0] sum,
  input  logic             ack,
  output logic [2:0]       out,
  output logic [1:0]       level,
  output logic             change,
  output logic             crit_latch,
  output logic [CNT_W-1:0] crit_count
);

  logic [1:0]       state_q, state_d;
  logic [2:0]       out_q, out_d;
  logic             chg_q, chg_d;
  logic             latch_q, latch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       raw;
  logic             take;
  logic [1:0]       new_lvl;
  logic             entering;

  assign raw = classify(32'(sum), state_q, 32'(TH_LOW),
                        32'(TH_HIGH), 32'(HYST));

  alarmas_persist #(
    .PERSIST(PERSIST)
  ) u_persist (
    .clk    (clk),
    .rst    (rst),
    .en     (sum_valid & ~sel),
    .clr    (sel),
    .state  (state_q),
    .raw    (raw),
    .take   (take),
    .new_lvl(new_lvl)
  );

  // Next state, decoded outputs, latch (set beats ack), counter.
  always_comb begin
    state_d  = take ? new_lvl : state_q;
    entering = take && (new_lvl == LVL_CRIT);
    out_d    = lvl2out(state_d);
    chg_d    = take;
    latch_d  = latch_q;
    if (entering)  latch_d = 1'b1;
    else if (ack)  latch_d = 1'b0;
    cnt_d = cnt_q;
    if (entering && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LVL_IDLE;
      out_q   <= OUT_IDLE;
      chg_q   <= 1'b0;
      latch_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      chg_q   <= chg_d;
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out        = out_q;
  assign level      = state_q;
  assign change     = chg_q;
  assign crit_latch = latch_q;
  assign crit_count = cnt_q;

endmodule

// File: tb/tb_alarmas_histeresis.sv
// Bench for alarmas_histeresis: vector table, directed corner
// sequences and random stimulus against a behavioural model.
module tb_alarmas_histeresis;

  localparam int P  = 4;
  localparam int TL = 103;
  localparam int TH = 256;
  localparam int HY = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       sum_valid = 1'b0;
  logic [8:0] sum = '0;
  logic       ack = 1'b0;

  logic [2:0] out, out2;
  logic [1:0] level, level2;
  logic       change, change2;
  logic       crit_latch, crit_latch2;
  logic [7:0] crit_count;
  logic [1:0] crit_count2;

  always #5 clk = ~clk;

  alarmas_histeresis u_dut (
    .clk(clk), .rst(rst), .sel(sel), .sum_valid(sum_valid),
    .sum(sum), .ack(ack), .out(out), .level(level),
    .change(change), .crit_latch(crit_latch),
    .crit_count(crit_count)
  );

  alarmas_histeresis #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .sel(sel), .sum_valid(sum_valid),
    .sum(sum), .ack(ack), .out(out2), .level(level2),
    .change(change2), .crit_latch(crit_latch2),
    .crit_count(crit_count2)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: level, window of recent raw classes.
  int m_lvl = 0;
  int hist[$];
  int m_chg = 0;
  int m_latch = 0;
  int m_cnt = 0;

  function automatic int cls(int s, int st);
    int t1, t2;
    t1 = TL + ((st == 1) ? HY : 0);
    t2 = TH + ((st == 1 || st == 2) ? HY : 0);
    if (s < t1) return 1;
    if (s < t2) return 2;
    return 3;
  endfunction

  task automatic model(input bit r, input bit s, input bit v,
                       input int sm, input bit a);
    bit ent;
    bit same;
    int c;
    ent = 1'b0;
    if (r) begin
      m_lvl = 0; hist.delete(); m_chg = 0;
      m_latch = 0; m_cnt = 0;
      return;
    end
    m_chg = 0;
    if (s) begin
      hist.delete();
    end else if (v) begin
      c = cls(sm, m_lvl);
      hist.push_back(c);
      if (hist.size() > P) void'(hist.pop_front());
      same = (hist.size() == P);
      foreach (hist[k]) if (hist[k] != c) same = 1'b0;
      if (same && c != m_lvl) begin
        m_lvl = c; m_chg = 1; hist.delete();
        ent = (c == 1);
      end
    end
    if (ent) m_latch = 1;
    else if (a) m_latch = 0;
    if (ent && m_cnt < 255) m_cnt++;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit v,
                      input int sm, input bit a);
    @(negedge clk);
    rst = r; sel = s; sum_valid = v; sum = sm[8:0]; ack = a;
    @(posedge clk);
    model(r, s, v, sm, a);
    #1;
    chk("level", 32'(level), 32'(m_lvl));
    chk("out", 32'(out), (m_lvl == 0) ? 0 : (1 << (m_lvl - 1)));
    chk("change", 32'(change), 32'(m_chg));
    chk("crit_latch", 32'(crit_latch), 32'(m_latch));
    chk("crit_count", 32'(crit_count), 32'(m_cnt));
    chk("crit_count_w2", 32'(crit_count2),
        32'((m_cnt > 3) ? 3 : m_cnt));
  endtask

  typedef struct {
    bit r; bit s; bit v; int sm; bit a; int lvl; bit chg;
  } vec_t;
  vec_t tbl[$];

  task automatic addn(input int n, input int sm, input int mid,
                      input int fin, input bit chg);
    vec_t e;
    for (int i = 0; i < n; i++) begin
      e = '{0, 0, 1, sm, 0, mid, 0};
      if (i == n - 1) begin e.lvl = fin; e.chg = chg; end
      tbl.push_back(e);
    end
  endtask

  int pts[13] = '{0, 50, 102, 103, 110, 111, 112,
                  255, 256, 263, 264, 265, 511};

  initial begin
    int hold, sv;
    bit rr, ss, vv, aa;

    tbl.push_back('{1, 0, 0, 0, 0, 0, 0});
    addn(4, 50, 0, 1, 1);
    addn(4, 105, 1, 1, 0);
    addn(4, 111, 1, 2, 1);
    addn(2, 300, 2, 2, 0);
    addn(1, 100, 2, 2, 0);
    addn(4, 300, 2, 3, 1);
    addn(4, 256, 3, 3, 0);
    addn(4, 255, 3, 2, 1);
    addn(4, 263, 2, 2, 0);
    addn(4, 264, 2, 3, 1);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].sm, tbl[i].a);
      chk("tbl_level", 32'(level), 32'(tbl[i].lvl));
      chk("tbl_change", 32'(change), 32'(tbl[i].chg));
    end

    // Freeze in ACEP, then a run cut by reset.
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
    chk("freeze_level", 32'(level), 32'd3);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    chk("pre_rst_level", 32'(level), 32'd3);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("rst_run_level", 32'(level), 32'd0);
    chk("rst_run_out", 32'(out), 32'd0);

    // Invalid cycles neither break nor extend a run.
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 50, 0);
    step(0, 0, 0, 400, 0);
    step(0, 0, 1, 50, 0);
    chk("gap_level", 32'(level), 32'd0);
    step(0, 0, 1, 50, 0);
    chk("gap_level2", 32'(level), 32'd1);
    chk("gap_change", 32'(change), 32'd1);

    // ack coinciding with CRIT entry, then ack alone.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 50, 0);
    step(0, 0, 1, 50, 1);
    chk("ack_set_wins", 32'(crit_latch), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("ack_clear", 32'(crit_latch), 32'd0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) step(0, 0, 1, 200, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 50, 0);
    end
    chk("count5", 32'(crit_count), 32'd5);
    chk("count_sat", 32'(crit_count2), 32'd3);

    // Random bursts near the thresholds.
    for (int n = 0; n < 3000; n += hold) begin
      hold = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 0) sv = pts[$urandom_range(0, 12)];
      else sv = $urandom_range(0, 511);
      for (int j = 0; j < hold; j++) begin
        rr = ($urandom_range(0, 99) == 0);
        ss = ($urandom_range(0, 7) == 0);
        vv = ($urandom_range(0, 3) != 0);
        aa = ($urandom_range(0, 15) == 0);
        step(rr, ss, vv, sv, aa);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
